// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad key decoder.
// Imported by keypad_code_lut and keypad_key_decoder.
package keypad_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DEBOUNCE,
        EMIT,
        HOLD,
        RELEASE
    } key_state_t;

    localparam logic [3:0] KEY_STAR      = 4'hE;
    localparam logic [3:0] KEY_HASH      = 4'hF;
    localparam logic [7:0] KEY_IDLE_CODE = 8'hFF;

    function automatic int unsigned ms_to_cycles(input int unsigned clk_freq,
                                                 input int unsigned ms);
        return clk_freq / 1000 * ms;
    endfunction

endpackage

// File: rtl/keypad_key_decoder_if.sv
// Scanner-to-decoder key bus.
// The scanner side drives the raw press and code; the decoder side returns the decoded key.
interface keypad_key_decoder_if;
    logic       key_pressed;
    logic [7:0] key_code_raw;
    logic       key_valid;
    logic       key_error;
    logic [3:0] key_value;
    logic       key_is_digit;

    modport master (
        output key_pressed, key_code_raw,
        input  key_valid, key_error, key_value, key_is_digit
    );

    modport slave (
        input  key_pressed, key_code_raw,
        output key_valid, key_error, key_value, key_is_digit
    );
endinterface

// File: rtl/keypad_code_lut.sv
// Combinational {cols,rows} (active-low) to {legal, key value} decode.
// Exactly one low column and one low row make a legal code.
module keypad_code_lut
    import keypad_pkg::*;
(
    input  logic [7:0] code,
    output logic       legal,
    output logic [3:0] value
);

    logic [1:0] col;
    logic [1:0] row;
    logic       col_ok;
    logic       row_ok;

    always_comb begin
        col    = '0;
        col_ok = 1'b1;
        case (code[7:4])
            4'b1110: col = 2'd0;
            4'b1101: col = 2'd1;
            4'b1011: col = 2'd2;
            4'b0111: col = 2'd3;
            default: col_ok = 1'b0;
        endcase

        row    = '0;
        row_ok = 1'b1;
        case (code[3:0])
            4'b1110: row = 2'd0;
            4'b1101: row = 2'd1;
            4'b1011: row = 2'd2;
            4'b0111: row = 2'd3;
            default: row_ok = 1'b0;
        endcase
    end

    always_comb begin
        legal = col_ok & row_ok;
        value = '0;
        case ({row, col})
            4'b00_00: value = 4'h1;
            4'b00_01: value = 4'h2;
            4'b00_10: value = 4'h3;
            4'b00_11: value = 4'hA;
            4'b01_00: value = 4'h4;
            4'b01_01: value = 4'h5;
            4'b01_10: value = 4'h6;
            4'b01_11: value = 4'hB;
            4'b10_00: value = 4'h7;
            4'b10_01: value = 4'h8;
            4'b10_10: value = 4'h9;
            4'b10_11: value = 4'hC;
            4'b11_00: value = KEY_STAR;
            4'b11_01: value = 4'h0;
            4'b11_10: value = KEY_HASH;
            default:  value = 4'hD;
        endcase
    end

endmodule

// File: rtl/keypad_key_decoder.sv
// Debounce/decode FSM for the keypad scanner: one key_valid or key_error pulse per press.
// Optional auto-repeat while held is enabled by defining KEYPAD_AUTOREPEAT_EN.
module keypad_key_decoder
    import keypad_pkg::*;
#(
    parameter int unsigned CLK_FREQ        = 27_000_000,
    parameter int unsigned DEBOUNCE_MS     = 10,
    parameter int unsigned RELEASE_MS      = 10,
    parameter int unsigned REPEAT_DELAY_MS = 500,
    parameter int unsigned REPEAT_RATE_MS  = 100
) (
    input  logic                 clk_27mhz,
    input  logic                 reset_n,
    keypad_key_decoder_if.slave  kbus
);

    localparam int unsigned DEB_CYC = ms_to_cycles(CLK_FREQ, DEBOUNCE_MS);
    localparam int unsigned REL_CYC = ms_to_cycles(CLK_FREQ, RELEASE_MS);
    localparam int unsigned MAX_CYC = (DEB_CYC > REL_CYC) ? DEB_CYC : REL_CYC;
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYC - 1);
    localparam logic [CNT_W-1:0] REL_LAST = CNT_W'(REL_CYC - 1);

    if (DEBOUNCE_MS == 0 || RELEASE_MS == 0 || REPEAT_DELAY_MS == 0 || REPEAT_RATE_MS == 0)
    begin : g_bad_timing
        $error("keypad_key_decoder: timing parameters must be non-zero");
    end

    key_state_t       state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [7:0]       code_q, code_d;
    logic             valid_q, valid_d;
    logic             error_q, error_d;
    logic [3:0]       value_q, value_d;
    logic             digit_q, digit_d;
    logic             lut_legal;
    logic [3:0]       lut_value;

    keypad_code_lut u_lut (
        .code  (code_q),
        .legal (lut_legal),
        .value (lut_value)
    );

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int unsigned RPT_DLY_CYC  = ms_to_cycles(CLK_FREQ, REPEAT_DELAY_MS);
    localparam int unsigned RPT_RATE_CYC = ms_to_cycles(CLK_FREQ, REPEAT_RATE_MS);
    localparam int unsigned RPT_MAX      = (RPT_DLY_CYC > RPT_RATE_CYC) ? RPT_DLY_CYC : RPT_RATE_CYC;
    localparam int unsigned RPT_W        = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;

    logic [RPT_W-1:0] rpt_cnt;
    logic             rpt_first;
    logic             rpt_hit;

    // First wrap uses the initial delay, later wraps the repeat period.
    assign rpt_hit = (rpt_cnt == (rpt_first ? RPT_W'(RPT_DLY_CYC - 1) : RPT_W'(RPT_RATE_CYC - 1)));

    always_ff @(posedge clk_27mhz or negedge reset_n) begin
        if (!reset_n) begin
            rpt_cnt   <= '0;
            rpt_first <= 1'b1;
        end else if (state != HOLD) begin
            rpt_cnt   <= '0;
            rpt_first <= 1'b1;
        end else if (rpt_hit) begin
            rpt_cnt   <= '0;
            rpt_first <= 1'b0;
        end else begin
            rpt_cnt   <= rpt_cnt + RPT_W'(1);
        end
    end
`endif

    always_ff @(posedge clk_27mhz or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            cnt     <= '0;
            code_q  <= KEY_IDLE_CODE;
            valid_q <= 1'b0;
            error_q <= 1'b0;
            value_q <= 4'h0;
            digit_q <= 1'b1;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            error_q <= error_d;
            value_q <= value_d;
            digit_q <= digit_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        code_d  = code_q;
        valid_d = 1'b0;
        error_d = 1'b0;
        value_d = value_q;
        digit_d = digit_q;

        case (state)
            IDLE: begin
                if (kbus.key_pressed) begin
                    code_d  = kbus.key_code_raw;
                    cnt_d   = '0;
                    state_d = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (!kbus.key_pressed || kbus.key_code_raw != code_q) begin
                    state_d = IDLE;
                end else if (cnt == DEB_LAST) begin
                    state_d = EMIT;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            EMIT: begin
                state_d = HOLD;
                if (lut_legal) begin
                    valid_d = 1'b1;
                    value_d = lut_value;
                    digit_d = (lut_value <= 4'd9);
                end else begin
                    error_d = 1'b1;
                end
            end
            HOLD: begin
                if (!kbus.key_pressed) begin
                    state_d = RELEASE;
                    cnt_d   = '0;
                end
`ifdef KEYPAD_AUTOREPEAT_EN
                else if (rpt_hit && lut_legal) begin
                    valid_d = 1'b1;
                end
`endif
            end
            RELEASE: begin
                if (kbus.key_pressed) begin
                    state_d = HOLD;
                end else if (cnt == REL_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign kbus.key_valid    = valid_q;
    assign kbus.key_error    = error_q;
    assign kbus.key_value    = value_q;
    assign kbus.key_is_digit = digit_q;

endmodule
